// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped, one-word-per-line instruction cache in front of the memory controller fetch port.
// Define ICACHE_STATS_EN to add the stat_hit/stat_miss counters.
module icache_ctrl #(
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        inv_all,
    output logic        if_stall,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc_o,
    output logic        mc_if_read,
    output logic [31:0] mc_if_addr,
    input  logic        mc_if_ready,
    input  logic [31:0] mc_if_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hit,
    output logic [31:0] stat_miss
`endif
);

    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
    localparam int unsigned LINES    = 2 ** INDEX_BITS;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                state;
    logic [LINES-1:0]      line_valid;
    logic [TAG_BITS-1:0]   line_tag  [LINES];
    logic [31:0]           line_data [LINES];
    logic [31:0]           miss_pc;
    logic                  drop;
    logic                  kill;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  hit;
    logic                  accept;
    logic                  fill;

    assign req_idx  = if_pc[INDEX_BITS+1:2];
    assign req_tag  = if_pc[31:INDEX_BITS+2];
    assign miss_idx = miss_pc[INDEX_BITS+1:2];
    assign miss_tag = miss_pc[31:INDEX_BITS+2];
    assign hit      = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign accept   = (state == IDLE) && if_req && !flush && !inv_all;
    // inv_all wins over a fill landing in the same cycle
    assign fill     = (state == WAIT) && mc_if_ready && !kill && !inv_all;
    assign if_stall = (state != IDLE);

    // Control FSM with registered IF and memory-controller outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            line_valid <= '0;
            if_valid   <= 1'b0;
            if_inst    <= '0;
            if_pc_o    <= '0;
            mc_if_read <= 1'b0;
            mc_if_addr <= '0;
            miss_pc    <= '0;
            drop       <= 1'b0;
            kill       <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            if (inv_all) line_valid <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            if_valid <= 1'b1;
                            if_inst  <= line_data[req_idx];
                            if_pc_o  <= if_pc;
                        end else begin
                            mc_if_read <= 1'b1;
                            mc_if_addr <= {if_pc[31:2], 2'b00};
                            miss_pc    <= if_pc;
                            drop       <= 1'b0;
                            kill       <= 1'b0;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush) drop <= 1'b1;
                    if (inv_all) kill <= 1'b1;
                    // a stale ready=1 is not completion; wait for the controller to pull it low
                    if (!mc_if_ready) begin
                        mc_if_read <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) drop <= 1'b1;
                    if (inv_all) kill <= 1'b1;
                    if (mc_if_ready) begin
                        if (fill) line_valid[miss_idx] <= 1'b1;
                        if (!drop && !kill && !flush && !inv_all) begin
                            if_valid <= 1'b1;
                            if_inst  <= mc_if_data;
                            if_pc_o  <= miss_pc;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line tag/data storage; validity lives in line_valid
    always_ff @(posedge clock) begin
        if (fill) begin
            line_tag[miss_idx]  <= miss_tag;
            line_data[miss_idx] <= mc_if_data;
        end
    end

`ifdef ICACHE_STATS_EN
    // Free-running hit/miss counters, wrap modulo 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_hit  <= '0;
            stat_miss <= '0;
        end else if (accept) begin
            if (hit) stat_hit <= stat_hit + 32'd1;
            else     stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: behavioural memory-controller model plus an address-map cache model.
module tb_icache_ctrl;

    localparam int M_NORMAL      = 0;
    localparam int M_FLUSH_WAIT  = 1;
    localparam int M_INV_WAIT    = 2;
    localparam int M_INV_DONE    = 3;
    localparam int M_FLUSH_REQ   = 4;
    localparam int M_INV_REQ     = 5;
    localparam int M_FLUSH_ISSUE = 6;
    localparam int NLINES        = 128;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_pc = '0;
    logic        flush = 1'b0;
    logic        inv_task = 1'b0;
    logic        inv_mc = 1'b0;
    logic        inv_all;
    logic        if_stall;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc_o;
    logic        mc_if_read;
    logic [31:0] mc_if_addr;
    logic        mc_if_ready = 1'b1;
    logic [31:0] mc_if_data = 32'hDEAD_BEEF;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;
`endif

    assign inv_all = inv_task | inv_mc;

    icache_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .if_req      (if_req),
        .if_pc       (if_pc),
        .flush       (flush),
        .inv_all     (inv_all),
        .if_stall    (if_stall),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc_o     (if_pc_o),
        .mc_if_read  (mc_if_read),
        .mc_if_addr  (mc_if_addr),
        .mc_if_ready (mc_if_ready),
        .mc_if_data  (mc_if_data)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hit    (stat_hit),
        .stat_miss   (stat_miss)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    bit          ref_v [NLINES];
    logic [31:0] ref_a [NLINES];

    // Memory controller model state
    int accept_delay = 0;
    int fetch_lat = 4;
    int acc_cnt = 0;
    int lat_cnt = 0;
    bit mc_busy = 1'b0;
    logic [31:0] mc_addr = '0;
    int done_cnt = 0;
    bit inv_arm = 1'b0;
    int inv_arm_at = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_0010) return 32'h0050_0093;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Byte-serial controller: accepts after accept_delay cycles, pulls ready low for fetch_lat cycles
    always @(negedge clock) begin
        inv_mc = 1'b0;
        if (mc_busy) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
                mc_busy     = 1'b0;
                mc_if_ready = 1'b1;
                mc_if_data  = mem_word(mc_addr);
                if (inv_arm && done_cnt == inv_arm_at) inv_mc = 1'b1;
                done_cnt = done_cnt + 1;
            end
        end else if (mc_if_read === 1'b1) begin
            if (acc_cnt >= accept_delay) begin
                mc_busy     = 1'b1;
                acc_cnt     = 0;
                lat_cnt     = fetch_lat;
                mc_addr     = mc_if_addr;
                mc_if_ready = 1'b0;
                mc_if_data  = 32'hDEAD_BEEF;
            end else begin
                acc_cnt = acc_cnt + 1;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NLINES; i++) ref_v[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic wait_mc_idle();
        int n;
        n = 0;
        while (mc_busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (mc_busy) begin
            errors++;
            $display("FAIL mc_idle_timeout: controller model still busy after %0d cycles", n);
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input int mode);
        int  idx;
        bit  exp_hit;
        bit  exp_valid;
        bit  injected;
        bit  done;
        bit  early_valid;
        int  reads;
        idx = int'((pc >> 2) % NLINES);
        exp_hit = ref_v[idx] && ((ref_a[idx] >> 2) == (pc >> 2));
        inv_arm = (mode == M_INV_DONE);
        inv_arm_at = done_cnt;
        @(negedge clock);
        if_req = 1'b1;
        if_pc = pc;
        flush = (mode == M_FLUSH_REQ);
        inv_task = (mode == M_INV_REQ);
        @(negedge clock);
        if_req = 1'b0;
        flush = 1'b0;
        inv_task = 1'b0;
        if (mode == M_FLUSH_REQ || mode == M_INV_REQ) begin
            checks++;
            if (if_valid !== 1'b0 || if_stall !== 1'b0 || mc_if_read !== 1'b0) begin
                errors++;
                $display("FAIL ignored_req pc=%h mode=%0d: valid=%b stall=%b read=%b expected 0 0 0",
                         pc, mode, if_valid, if_stall, mc_if_read);
            end
            if (mode == M_INV_REQ) model_clear();
            return;
        end
        if (exp_hit) begin
            exp_hits++;
            checks++;
            if (if_valid !== 1'b1 || if_inst !== mem_word(pc) || if_pc_o !== pc ||
                mc_if_read !== 1'b0 || if_stall !== 1'b0) begin
                errors++;
                $display("FAIL hit pc=%h: valid=%b inst=%h pc_o=%h read=%b stall=%b expected 1 %h %h 0 0",
                         pc, if_valid, if_inst, if_pc_o, mc_if_read, if_stall, mem_word(pc), pc);
            end
            return;
        end
        exp_misses++;
        checks++;
        if (if_stall !== 1'b1 || mc_if_read !== 1'b1 || mc_if_addr !== (pc & 32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL miss_issue pc=%h: stall=%b read=%b addr=%h expected 1 1 %h",
                     pc, if_stall, mc_if_read, mc_if_addr, pc & 32'hFFFF_FFFC);
        end
        reads = 0;
        injected = 1'b0;
        done = 1'b0;
        early_valid = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc > 0) begin
                @(negedge clock);
                flush = 1'b0;
                inv_task = 1'b0;
            end
            if (if_stall !== 1'b1) begin
                done = 1'b1;
                break;
            end
            if (mc_if_read === 1'b1) reads++;
            if (if_valid !== 1'b0) early_valid = 1'b1;
            if (!injected) begin
                if (mode == M_FLUSH_ISSUE && mc_if_read === 1'b1) begin
                    flush = 1'b1;
                    injected = 1'b1;
                end else if (mode == M_FLUSH_WAIT && mc_if_read === 1'b0) begin
                    flush = 1'b1;
                    injected = 1'b1;
                end else if (mode == M_INV_WAIT && mc_if_read === 1'b0) begin
                    inv_task = 1'b1;
                    injected = 1'b1;
                end
            end
        end
        inv_arm = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL miss_timeout pc=%h: still stalled after 200 cycles, expected completion", pc);
            return;
        end
        checks++;
        if (reads != accept_delay + 1 || early_valid) begin
            errors++;
            $display("FAIL miss_handshake pc=%h: read_cycles=%0d early_valid=%b expected %0d 0",
                     pc, reads, early_valid, accept_delay + 1);
        end
        exp_valid = (mode == M_NORMAL);
        checks++;
        if (if_valid !== exp_valid ||
            (exp_valid && (if_inst !== mem_word(pc) || if_pc_o !== pc))) begin
            errors++;
            $display("FAIL miss_resp pc=%h mode=%0d: valid=%b inst=%h pc_o=%h expected %b %h %h",
                     pc, mode, if_valid, if_inst, if_pc_o, exp_valid, mem_word(pc), pc);
        end
        if (mode == M_INV_WAIT || mode == M_INV_DONE) begin
            model_clear();
        end else begin
            ref_v[idx] = 1'b1;
            ref_a[idx] = pc;
        end
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse pc=%h: valid=%b one cycle later, expected 0", pc, if_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_clear();
        @(negedge clock);
        checks++;
        if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc_o !== 32'h0 || mc_if_read !== 1'b0 ||
            mc_if_addr !== 32'h0 || if_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b inst=%h pc_o=%h read=%b addr=%h stall=%b expected all 0",
                     if_valid, if_inst, if_pc_o, mc_if_read, mc_if_addr, if_stall);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (stat_hit !== 32'h0 || stat_miss !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: hit=%0d miss=%0d expected 0 0", stat_hit, stat_miss);
        end
`endif
    endtask

    task automatic test_directed();
        accept_delay = 1;
        fetch_lat = 4;
        fetch(32'h0000_0010, M_NORMAL);      // cold miss
        fetch(32'h0000_0010, M_NORMAL);      // hit
        fetch(32'h0000_0210, M_NORMAL);      // conflict refill
        fetch(32'h0000_0010, M_NORMAL);      // evicted -> miss
        accept_delay = 3;
        fetch(32'h0000_0014, M_NORMAL);      // stale ready, delayed acceptance
        accept_delay = 0;
        fetch(32'h0000_0020, M_FLUSH_WAIT);
        fetch(32'h0000_0020, M_NORMAL);      // filled despite flush -> hit
        fetch(32'h0000_0030, M_INV_WAIT);
        fetch(32'h0000_0010, M_NORMAL);      // invalidated -> miss
        fetch(32'h0000_0034, M_INV_DONE);
        fetch(32'h0000_0034, M_NORMAL);      // not filled -> miss
        fetch(32'h0000_0044, M_FLUSH_ISSUE);
        fetch(32'hFFFF_FFFC, M_NORMAL);
        fetch(32'hFFFF_FFFC, M_NORMAL);
        fetch(32'h0000_01FC, M_NORMAL);      // same top index
        fetch(32'h0000_01FC, M_FLUSH_REQ);
        fetch(32'h0000_01FC, M_INV_REQ);
        fetch(32'h0000_01FC, M_NORMAL);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [4];
        for (int i = 0; i < 4; i++) begin
            pcs[i] = 32'h0000_0100 + 32'(i * 4);
            fetch(pcs[i], M_NORMAL);
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clock);
            if (i > 0) begin
                exp_hits++;
                checks++;
                if (if_valid !== 1'b1 || if_inst !== mem_word(pcs[i-1]) || if_pc_o !== pcs[i-1] ||
                    if_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b[%0d]: valid=%b inst=%h pc_o=%h stall=%b expected 1 %h %h 0",
                             i - 1, if_valid, if_inst, if_pc_o, if_stall, mem_word(pcs[i-1]), pcs[i-1]);
                end
            end
            if (i < 4) begin
                if_req = 1'b1;
                if_pc = pcs[i];
            end else begin
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_miss();
        int n;
        accept_delay = 0;
        fetch_lat = 7;
        @(negedge clock);
        if_req = 1'b1;
        if_pc = 32'h0000_0060;
        @(negedge clock);
        if_req = 1'b0;
        n = 0;
        while (mc_if_read === 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        pulse_reset();
        checks++;
        if (if_stall !== 1'b0 || mc_if_read !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_miss: stall=%b read=%b valid=%b expected 0 0 0",
                     if_stall, mc_if_read, if_valid);
        end
        wait_mc_idle();
        accept_delay = 2;
        fetch_lat = 5;
        fetch(32'h0000_0060, M_NORMAL);      // ready still high from the abandoned fetch
        fetch(32'h0000_0060, M_NORMAL);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        int r;
        int mode;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFFC;
            else pc = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2);
            r = int'($urandom_range(0, 99));
            if      (r < 70) mode = M_NORMAL;
            else if (r < 78) mode = M_FLUSH_WAIT;
            else if (r < 83) mode = M_INV_WAIT;
            else if (r < 86) mode = M_INV_DONE;
            else if (r < 90) mode = M_FLUSH_REQ;
            else if (r < 93) mode = M_INV_REQ;
            else             mode = M_FLUSH_ISSUE;
            accept_delay = int'($urandom_range(0, 3));
            fetch_lat = int'($urandom_range(4, 7));
            fetch(pc, mode);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (stat_hit !== 32'(exp_hits) || stat_miss !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL random_stats: hit=%0d miss=%0d expected %0d %0d",
                     stat_hit, stat_miss, exp_hits, exp_misses);
        end
`endif
    endtask

    task automatic test_stats();
        pulse_reset();
        accept_delay = 1;
        fetch_lat = 4;
        fetch(32'h0000_0040, M_NORMAL);
        fetch(32'h0000_0040, M_NORMAL);
        fetch(32'h0000_0040, M_NORMAL);
        fetch(32'h0000_0044, M_NORMAL);
        fetch(32'h0000_0048, M_FLUSH_WAIT);
`ifdef ICACHE_STATS_EN
        checks++;
        if (stat_hit !== 32'd2 || stat_miss !== 32'd3) begin
            errors++;
            $display("FAIL stats_seq: hit=%0d miss=%0d expected 2 3", stat_hit, stat_miss);
        end
        pulse_reset();
        checks++;
        if (stat_hit !== 32'd0 || stat_miss !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: hit=%0d miss=%0d expected 0 0", stat_hit, stat_miss);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_miss();
        test_random();
        test_stats();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
